get_target_tracker: RTL and testbench
=====================================

Name: get_target_tracker

Overview:
- Parametrised, N-channel successor to the fixed four-target detection wrapper.
- Takes the raw per-frame target results from the detector as packed buses: x, y, diameter and valid for NUM_TARGETS channels.
- Samples them once per frame at the vsync rising edge and applies per-channel temporal smoothing, jump re-acquisition and loss hysteresis.
- Presents frame-stable outputs plus a one-cycle update strobe to downstream overlay/pose logic.

Parameters:
NUM_TARGETS, 4, number of target channels (>=1)
SCREEN_WIDTH, 1280, sets X_W = $clog2(SCREEN_WIDTH)
SCREEN_HEIGHT, 720, sets Y_W = $clog2(SCREEN_HEIGHT)+1 (used for y and diameter)
SMOOTH_SHIFT, 1, smoothing step = (raw-old)>>>SMOOTH_SHIFT; 0 = pass-through
JUMP_THRES, 64, |raw-old| in x or y strictly greater than this forces direct reload
HOLD_FRAMES, 3, consecutive missing frames tolerated before channel drops; 0 = drop immediately
FRAME_CNT_W, 16, width of frame counter

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  reset
vsync_in  input  1  vertical sync, synchronous to clk_in, active-high
xcount_in  input  NUM_TARGETS*X_W  raw x; channel i at [i*X_W +: X_W]
ycount_in  input  NUM_TARGETS*Y_W  raw y; channel i at [i*Y_W +: Y_W]
diameter_in  input  NUM_TARGETS*Y_W  raw diameter, same packing as ycount_in
valid_in  input  NUM_TARGETS  raw valid; bit i = channel i (no bit reversal)
xcount_out  output  NUM_TARGETS*X_W  tracked x, same packing as xcount_in
ycount_out  output  NUM_TARGETS*Y_W  tracked y
diameter_out  output  NUM_TARGETS*Y_W  tracked diameter
valid_out  output  NUM_TARGETS  tracked valid, bit i = channel i
frame_strobe_out  output  1  one-cycle pulse when outputs have just updated
frame_count_out  output  FRAME_CNT_W  frames processed, wraps

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset state: every output register, per-channel age counter and the vsync history register are cleared to 0. Reset mid-frame aborts everything immediately. The first vsync rising edge after reset release is treated as a normal frame.
- Frame event: vsync_in==1 while the registered previous vsync==0.
  - vsync held high for many cycles produces exactly one event.
  - vsync high during reset release produces no event until it falls and rises again.
- Latency: event sampled in cycle N. All channel registers, frame_count_out (+1, wraps to 0) and frame_strobe_out=1 are visible from cycle N+1. Strobe is 0 in cycle N+2 unless a new event occurs. Between events all outputs hold.
- Per channel i at each event, with age_i as a saturating counter 0..HOLD_FRAMES:
  - valid_in[i]=1 and (valid_out[i]=0 or |x_raw-x_old|>JUMP_THRES or |y_raw-y_old|>JUMP_THRES): load x, y and diameter directly from raw; age_i=0; valid_out[i]=1.
  - valid_in[i]=1 otherwise: for each of x, y and diameter, new = old + ((raw-old)>>>SMOOTH_SHIFT); age_i=0; valid_out[i]=1.
  - valid_in[i]=0: coordinates hold; age_i = min(age_i+1, HOLD_FRAMES); valid_out[i]=0 iff the new age_i == HOLD_FRAMES. With HOLD_FRAMES=0, valid_out[i] drops on the first missing frame.
- Arithmetic:
  - Differences are computed signed at field width + 1. >>> is arithmetic (rounds toward negative infinity).
  - The result always lies between old and raw inclusive, so no overflow or clamping is needed.
  - A residual difference of +1..(2^SMOOTH_SHIFT-1) can persist; this is accepted.
- Channels are fully independent. All channels update on the same edge.

Test Plan:
- Reset, then assert rst_in asynchronously mid-frame -> all outputs 0 immediately, with no clock edge needed; frame_count_out=0.
- Frame 1, ch0 valid, x=100 y=50 d=20 -> next cycle ch0 outputs 100/50/20, valid_out=4'b0001, frame_strobe_out high exactly one cycle, frame_count_out=1.
- Frame 2, ch0 x=110 y=54 d=24 -> outputs 105/52/22. Frame 3, x=106 -> 105 (diff +1>>>1=0). Frame 3 alt, x=98 -> 101 (diff -7>>>1=-4).
- Frame with ch0 x=300 (diff 195 > 64) -> direct load, x=300, y and d from raw.
- ch2 valid (x=400) then 3 frames valid_in[2]=0 -> valid_out[2] stays 1 after missing frames 1 and 2, goes 0 after frame 3, x holds 400. Next valid frame x=700 -> direct load 700.
- vsync held high 50 cycles, then low, then high -> exactly two strobes and frame_count_out incremented by 2. NUM_TARGETS=1 and NUM_TARGETS=8 builds repeat the frame 1 and frame 2 cases on the top channel.

Source files
------------

// File: rtl/get_target_tracker.sv
// N-channel target tracker: samples raw detector results once per frame and
// applies temporal smoothing, jump re-acquisition and loss hysteresis.
module get_target_tracker #(
    parameter int NUM_TARGETS   = 4,
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int SMOOTH_SHIFT  = 1,
    parameter int JUMP_THRES    = 64,
    parameter int HOLD_FRAMES   = 3,
    parameter int FRAME_CNT_W   = 16,
    localparam int X_W = $clog2(SCREEN_WIDTH),
    localparam int Y_W = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         vsync_in,
    input  logic [NUM_TARGETS*X_W-1:0]   xcount_in,
    input  logic [NUM_TARGETS*Y_W-1:0]   ycount_in,
    input  logic [NUM_TARGETS*Y_W-1:0]   diameter_in,
    input  logic [NUM_TARGETS-1:0]       valid_in,
    output logic [NUM_TARGETS*X_W-1:0]   xcount_out,
    output logic [NUM_TARGETS*Y_W-1:0]   ycount_out,
    output logic [NUM_TARGETS*Y_W-1:0]   diameter_out,
    output logic [NUM_TARGETS-1:0]       valid_out,
    output logic                         frame_strobe_out,
    output logic [FRAME_CNT_W-1:0]       frame_count_out
);

    localparam int F_W   = (X_W > Y_W) ? X_W : Y_W;
    localparam int AGE_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [F_W:0]       JUMP = (F_W+1)'(JUMP_THRES);
    localparam logic [AGE_W-1:0]   HOLD = AGE_W'(HOLD_FRAMES);

    function automatic logic signed [F_W:0] delta(
        input logic [F_W-1:0] raw,
        input logic [F_W-1:0] old
    );
        return $signed({1'b0, raw}) - $signed({1'b0, old});
    endfunction

    // Step lies between 0 and the full difference, so F_W bits suffice.
    function automatic logic [F_W-1:0] smooth(
        input logic [F_W-1:0] raw,
        input logic [F_W-1:0] old
    );
        logic signed [F_W:0] d;
        logic signed [F_W:0] step;
        d    = delta(raw, old);
        step = d >>> SMOOTH_SHIFT;
        return old + step[F_W-1:0];
    endfunction

    function automatic logic is_jump(
        input logic [F_W-1:0] raw,
        input logic [F_W-1:0] old
    );
        logic signed [F_W:0] d;
        logic [F_W:0]        mag;
        d   = delta(raw, old);
        mag = d[F_W] ? $unsigned(-d) : $unsigned(d);
        return mag > JUMP;
    endfunction

    logic vs_q;
    logic armed_q;
    logic frame_evt;

    // armed_q keeps a vsync already high at reset release from counting.
    assign frame_evt = vsync_in & ~vs_q & armed_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vs_q             <= 1'b0;
            armed_q          <= 1'b0;
            frame_strobe_out <= 1'b0;
            frame_count_out  <= '0;
        end else begin
            vs_q             <= vsync_in;
            frame_strobe_out <= frame_evt;
            if (!vsync_in)
                armed_q <= 1'b1;
            if (frame_evt)
                frame_count_out <= frame_count_out + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_ch
        logic [X_W-1:0]   x_q;
        logic [Y_W-1:0]   y_q;
        logic [Y_W-1:0]   d_q;
        logic             v_q;
        logic [AGE_W-1:0] age_q;
        logic [AGE_W-1:0] age_nx;
        logic [X_W-1:0]   x_raw;
        logic [Y_W-1:0]   y_raw;
        logic [Y_W-1:0]   d_raw;
        logic             reload;

        assign x_raw = xcount_in[i*X_W +: X_W];
        assign y_raw = ycount_in[i*Y_W +: Y_W];
        assign d_raw = diameter_in[i*Y_W +: Y_W];

        assign reload = ~v_q
                      | is_jump(F_W'(x_raw), F_W'(x_q))
                      | is_jump(F_W'(y_raw), F_W'(y_q));

        assign age_nx = (age_q >= HOLD) ? HOLD : age_q + 1'b1;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                x_q   <= '0;
                y_q   <= '0;
                d_q   <= '0;
                v_q   <= 1'b0;
                age_q <= '0;
            end else if (frame_evt) begin
                if (valid_in[i]) begin
                    age_q <= '0;
                    v_q   <= 1'b1;
                    if (reload) begin
                        x_q <= x_raw;
                        y_q <= y_raw;
                        d_q <= d_raw;
                    end else begin
                        x_q <= X_W'(smooth(F_W'(x_raw), F_W'(x_q)));
                        y_q <= Y_W'(smooth(F_W'(y_raw), F_W'(y_q)));
                        d_q <= Y_W'(smooth(F_W'(d_raw), F_W'(d_q)));
                    end
                end else begin
                    age_q <= age_nx;
                    v_q   <= v_q & (age_nx != HOLD);
                end
            end
        end

        assign xcount_out[i*X_W +: X_W]   = x_q;
        assign ycount_out[i*Y_W +: Y_W]   = y_q;
        assign diameter_out[i*Y_W +: Y_W] = d_q;
        assign valid_out[i]               = v_q;
    end

endmodule

// File: tb/tb_get_target_tracker.sv
// Directed bench for get_target_tracker: 4-channel build plus 1- and
// 8-channel builds fed with channel 0 stimulus on their top channel.
module tb_get_target_tracker;

    localparam int XW = 11;
    localparam int YW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b0;

    logic [XW-1:0] rx [4];
    logic [YW-1:0] ry [4];
    logic [YW-1:0] rd [4];
    logic [3:0]    rv;

    logic [4*XW-1:0] xin, xout;
    logic [4*YW-1:0] yin, yout, din, dout;
    logic [3:0]      vout;
    logic            strobe;
    logic [15:0]     fcnt;

    logic [XW-1:0] x1o;
    logic [YW-1:0] y1o, d1o;
    logic          v1o, s1;
    logic [15:0]   c1;

    logic [8*XW-1:0] x8i, x8o;
    logic [8*YW-1:0] y8i, y8o, d8i, d8o;
    logic [7:0]      v8i, v8o;
    logic            s8;
    logic [15:0]     c8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign xin = {rx[3], rx[2], rx[1], rx[0]};
    assign yin = {ry[3], ry[2], ry[1], ry[0]};
    assign din = {rd[3], rd[2], rd[1], rd[0]};
    assign x8i = {rx[0], {(7*XW){1'b0}}};
    assign y8i = {ry[0], {(7*YW){1'b0}}};
    assign d8i = {rd[0], {(7*YW){1'b0}}};
    assign v8i = {rv[0], 7'b0};

    get_target_tracker u_dut (
        .clk_in(clk), .rst_in(rst), .vsync_in(vsync),
        .xcount_in(xin), .ycount_in(yin),
        .diameter_in(din), .valid_in(rv),
        .xcount_out(xout), .ycount_out(yout),
        .diameter_out(dout), .valid_out(vout),
        .frame_strobe_out(strobe), .frame_count_out(fcnt)
    );

    get_target_tracker #(.NUM_TARGETS(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .vsync_in(vsync),
        .xcount_in(rx[0]), .ycount_in(ry[0]),
        .diameter_in(rd[0]), .valid_in(rv[0]),
        .xcount_out(x1o), .ycount_out(y1o),
        .diameter_out(d1o), .valid_out(v1o),
        .frame_strobe_out(s1), .frame_count_out(c1)
    );

    get_target_tracker #(.NUM_TARGETS(8)) u_dut8 (
        .clk_in(clk), .rst_in(rst), .vsync_in(vsync),
        .xcount_in(x8i), .ycount_in(y8i),
        .diameter_in(d8i), .valid_in(v8i),
        .xcount_out(x8o), .ycount_out(y8o),
        .diameter_out(d8o), .valid_out(v8o),
        .frame_strobe_out(s8), .frame_count_out(c8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_ch(input int i, input logic v, input int x,
                          input int y, input int d);
        rv[i] = v;
        rx[i] = XW'(x);
        ry[i] = YW'(y);
        rd[i] = YW'(d);
    endtask

    task automatic frame();
        @(posedge clk);
        #1 vsync = 1'b1;
        @(posedge clk);
        #1 vsync = 1'b0;
    endtask

    task automatic check_ch(input string tag, input int i, input int x,
                            input int y, input int d);
        check({tag, ".x"}, 32'(xout[i*XW +: XW]), x);
        check({tag, ".y"}, 32'(yout[i*YW +: YW]), y);
        check({tag, ".d"}, 32'(dout[i*YW +: YW]), d);
    endtask

    task automatic check_top(input string tag, input int x, input int y,
                             input int d);
        check({tag, ".n1x"}, 32'(x1o), x);
        check({tag, ".n1y"}, 32'(y1o), y);
        check({tag, ".n1d"}, 32'(d1o), d);
        check({tag, ".n1v"}, 32'(v1o), 1);
        check({tag, ".n8x"}, 32'(x8o[7*XW +: XW]), x);
        check({tag, ".n8y"}, 32'(y8o[7*YW +: YW]), y);
        check({tag, ".n8d"}, 32'(d8o[7*YW +: YW]), d);
        check({tag, ".n8v"}, 32'(v8o), 32'h80);
    endtask

    initial begin
        int strobes;
        logic [15:0] c0;

        for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 0, 0, 0);
        #2;
        check("rst.x0", 32'(xout), 0);
        check("rst.valid", 32'(vout), 0);
        check("rst.cnt", 32'(fcnt), 0);
        check("rst.strobe", 32'(strobe), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Populate state, then reset asynchronously between edges.
        #1 set_ch(0, 1'b1, 123, 45, 6);
        frame();
        check_ch("pre", 0, 123, 45, 6);
        check("pre.cnt", 32'(fcnt), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async.x0", 32'(xout[XW-1:0]), 0);
        check("async.valid", 32'(vout), 0);
        check("async.cnt", 32'(fcnt), 0);
        check("async.n8x", 32'(x8o[7*XW +: XW]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        #1 set_ch(0, 1'b1, 100, 50, 20);
        frame();
        check_ch("f1", 0, 100, 50, 20);
        check("f1.valid", 32'(vout), 4'b0001);
        check("f1.strobe", 32'(strobe), 1);
        check("f1.cnt", 32'(fcnt), 1);
        check_top("f1", 100, 50, 20);
        @(posedge clk);
        #1;
        check("f1.strobe_low", 32'(strobe), 0);
        check("f1.hold_x", 32'(xout[XW-1:0]), 100);
        check("f1.hold_cnt", 32'(fcnt), 1);

        set_ch(0, 1'b1, 110, 54, 24);
        frame();
        check_ch("f2", 0, 105, 52, 22);
        check("f2.cnt", 32'(fcnt), 2);
        check_top("f2", 105, 52, 22);

        set_ch(0, 1'b1, 106, 52, 22);
        frame();
        check_ch("f3_residual", 0, 105, 52, 22);

        set_ch(0, 1'b1, 98, 52, 22);
        frame();
        check_ch("f3_neg", 0, 101, 52, 22);

        set_ch(0, 1'b1, 300, 60, 30);
        frame();
        check_ch("jump_x", 0, 300, 60, 30);

        set_ch(0, 1'b1, 300, 200, 10);
        frame();
        check_ch("jump_y", 0, 300, 200, 10);

        set_ch(0, 1'b1, 364, 200, 10);
        frame();
        check_ch("thres_eq", 0, 332, 200, 10);

        set_ch(0, 1'b1, 267, 200, 10);
        frame();
        check_ch("jump_neg", 0, 267, 200, 10);
        check("jump.cnt", 32'(fcnt), 8);

        set_ch(2, 1'b1, 400, 100, 8);
        frame();
        check_ch("ch2_load", 2, 400, 100, 8);
        check("ch2.valid", 32'(vout), 4'b0101);
        check_ch("ch0_still", 0, 267, 200, 10);

        set_ch(2, 1'b0, 0, 0, 0);
        frame();
        check("miss1.valid", 32'(vout), 4'b0101);
        frame();
        check("miss2.valid", 32'(vout), 4'b0101);
        frame();
        check("miss3.valid", 32'(vout), 4'b0001);
        check_ch("miss3_hold", 2, 400, 100, 8);

        set_ch(2, 1'b1, 700, 100, 8);
        frame();
        check_ch("ch2_reacq", 2, 700, 100, 8);
        check("reacq.valid", 32'(vout), 4'b0101);
        check("reacq.cnt", 32'(fcnt), 13);

        // Long vsync pulse must count once; a second rise counts again.
        c0 = fcnt;
        strobes = 0;
        @(posedge clk);
        #1 vsync = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1 if (strobe) strobes++;
        end
        vsync = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 if (strobe) strobes++;
        end
        vsync = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 if (strobe) strobes++;
        end
        vsync = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (strobe) strobes++;
        end
        check("long_vs.strobes", strobes, 2);
        check("long_vs.cnt", 32'(fcnt), 32'(16'(c0 + 16'd2)));

        // vsync already high when reset releases: no event yet.
        @(posedge clk);
        #3 rst = 1'b1;
        vsync = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        strobes = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (strobe) strobes++;
        end
        check("rel_high.strobes", strobes, 0);
        check("rel_high.cnt", 32'(fcnt), 0);
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        frame();
        check("rel_high.evt", 32'(strobe), 1);
        check("rel_high.cnt1", 32'(fcnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
